// File: rtl/seq_alu_if.sv
// Valid/ready operand and result bus for seq_alu.
// The master drives operands and the consumer ready; the slave returns the result.
interface seq_alu_if #(
    parameter int WIDTH = 8,
    parameter int OP_W  = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] ra_in;
    logic [WIDTH-1:0] rb_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res_out;
    logic [WIDTH-1:0] car_out;
    logic             zero;
    logic             jump;

    modport master (
        output in_valid, op, ra_in, rb_in, out_ready,
        input  in_ready, out_valid, res_out, car_out, zero, jump
    );

    modport slave (
        input  in_valid, op, ra_in, rb_in, out_ready,
        output in_ready, out_valid, res_out, car_out, zero, jump
    );
endinterface

// File: rtl/seq_alu.sv
// Registered, handshaked ALU with saturating add/sub, shifts with carry-out,
// an EQ branch flag and an iterative signed multiply.
//   state | meaning
//   IDLE  | no result pending, ready to accept an op
//   BUSY  | MUL iterating, one multiplier bit per cycle
//   DONE  | result held until the consumer takes it
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int OP_W  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    seq_alu_if.slave     bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SLT  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SRL  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SRA  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_EQ   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_MUL  = OP_W'(9);
    localparam logic [WIDTH:0]  SH_LIM  = (WIDTH+1)'(2*WIDTH);
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]   ra, rb;
    logic               accept, is_mul;
    logic [WIDTH-1:0]   res_c, car_c;
    logic               jump_c;
    logic [WIDTH:0]     sum_add, sum_sub;
    logic [2*WIDTH-1:0] srl_v, sra_v;
    logic               sh_big;

    logic [WIDTH-1:0]   res_q, car_q;
    logic               zero_q, jump_q;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mc, acc, acc_nxt, addend;
    logic [WIDTH-1:0]   mp;

    assign ra     = bus.ra_in;
    assign rb     = bus.rb_in;
    assign is_mul = (bus.op == OP_MUL);

    assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready && !flush;
    assign bus.out_valid = (state == DONE);
    assign bus.res_out   = res_q;
    assign bus.car_out   = car_q;
    assign bus.zero      = zero_q;
    assign bus.jump      = jump_q;

    // Returns {car, res}; the extra sum bit disagreeing with the sign bit flags saturation.
    function automatic logic [2*WIDTH-1:0] saturate(input logic [WIDTH:0] s);
        if (s[WIDTH] == s[WIDTH-1])
            saturate = {{WIDTH{1'b0}}, s[WIDTH-1:0]};
        else if (!s[WIDTH])
            saturate = {{{(WIDTH-1){1'b0}}, 1'b1}, MAX_POS};
        else
            saturate = {{WIDTH{1'b1}}, MIN_NEG};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = is_mul ? BUSY : DONE;
            BUSY: if (cnt == '0) state_nxt = DONE;
            DONE: begin
                if (bus.out_ready) begin
                    if (accept) state_nxt = is_mul ? BUSY : DONE;
                    else        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_comb begin
        sum_add = {ra[WIDTH-1], ra} + {rb[WIDTH-1], rb};
        sum_sub = {ra[WIDTH-1], ra} - {rb[WIDTH-1], rb};
        sh_big  = ({1'b0, rb} >= SH_LIM);
        srl_v   = {ra, {WIDTH{1'b0}}} >> rb;
        sra_v   = $signed({ra, {WIDTH{1'b0}}}) >>> rb;
        res_c   = ra;
        car_c   = '0;
        jump_c  = 1'b0;
        case (bus.op)
            OP_AND: res_c = ra & rb;
            OP_SLT: res_c = {{(WIDTH-1){1'b0}}, ($signed(ra) < $signed(rb))};
            OP_OR:  res_c = ra | rb;
            OP_ADD: {car_c, res_c} = saturate(sum_add);
            OP_SUB: {car_c, res_c} = saturate(sum_sub);
            OP_SRL: {res_c, car_c} = sh_big ? '0 : srl_v;
            OP_SRA: {res_c, car_c} = sh_big ? {(2*WIDTH){ra[WIDTH-1]}} : sra_v;
            OP_EQ: begin
                res_c  = '0;
                jump_c = (ra == rb);
            end
            default: res_c = ra;
        endcase
    end

    // Last multiplier bit carries negative weight in two's complement, so it subtracts.
    always_comb begin
        addend = '0;
        if (mp[0]) addend = (cnt == '0) ? ('0 - mc) : mc;
        acc_nxt = acc + addend;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= '0;
            car_q  <= '0;
            zero_q <= 1'b0;
            jump_q <= 1'b0;
            cnt    <= '0;
            mc     <= '0;
            mp     <= '0;
            acc    <= '0;
        end else if (!flush) begin
            if (accept) begin
                if (is_mul) begin
                    mc  <= {{WIDTH{ra[WIDTH-1]}}, ra};
                    mp  <= rb;
                    acc <= '0;
                    cnt <= CW'(WIDTH-1);
                end else begin
                    res_q  <= res_c;
                    car_q  <= car_c;
                    zero_q <= (res_c == '0);
                    jump_q <= jump_c;
                end
            end else if (state == BUSY) begin
                acc <= acc_nxt;
                mc  <= mc << 1;
                mp  <= mp >> 1;
                if (cnt == '0) begin
                    res_q  <= acc_nxt[WIDTH-1:0];
                    car_q  <= acc_nxt[2*WIDTH-1:WIDTH];
                    zero_q <= (acc_nxt[WIDTH-1:0] == '0);
                    jump_q <= 1'b0;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=8): hand-computed vectors with immediate assertions.
module tb_seq_alu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   lat;
    logic seen;

    seq_alu_if #(.WIDTH(8), .OP_W(4)) bus ();

    seq_alu #(.WIDTH(8), .OP_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.ra_in    = a;
        bus.rb_in    = b;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_res(input string tag, input logic [7:0] r, input logic [7:0] c);
        check({tag, " valid"}, 16'(bus.out_valid), 16'h1);
        check({tag, " res"},   16'(bus.res_out),   16'(r));
        check({tag, " car"},   16'(bus.car_out),   16'(c));
    endtask

    task automatic wait_valid(input int max, output int cycles);
        cycles = 1;
        while (!bus.out_valid && cycles < max) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.ra_in     = '0;
        bus.rb_in     = '0;
        bus.out_ready = 1'b1;

        tick();
        check("rst out_valid", 16'(bus.out_valid), 16'h0);
        check("rst res",       16'(bus.res_out),   16'h0);
        check("rst car",       16'(bus.car_out),   16'h0);
        check("rst zero",      16'(bus.zero),      16'h0);
        check("rst jump",      16'(bus.jump),      16'h0);
        rst_n = 1'b1;
        tick();
        check("idle in_ready", 16'(bus.in_ready),  16'h1);

        // Saturating add, back-to-back
        issue(4'd3, 8'd100, 8'd50);  expect_res("add ovf", 8'h7F, 8'h01);
        issue(4'd3, 8'h9C, 8'hCE);   expect_res("add unf", 8'h80, 8'hFF);
        issue(4'd3, 8'd20, 8'd30);   expect_res("add ok",  8'd50, 8'h00);
        check("add ok zero", 16'(bus.zero), 16'h0);
        tick();
        check("drain valid", 16'(bus.out_valid), 16'h0);

        issue(4'd8, 8'h9C, 8'd50);   expect_res("sub unf", 8'h80, 8'hFF);
        issue(4'd8, 8'd100, 8'hCE);  expect_res("sub ovf", 8'h7F, 8'h01);
        issue(4'd8, 8'd10, 8'd3);    expect_res("sub ok",  8'd7,  8'h00);
        issue(4'd1, 8'hFF, 8'h01);   expect_res("slt t",   8'h01, 8'h00);
        issue(4'd1, 8'h01, 8'hFF);   expect_res("slt f",   8'h00, 8'h00);
        issue(4'd2, 8'hA0, 8'h05);   expect_res("or",      8'hA5, 8'h00);
        issue(4'd12, 8'h3C, 8'h11);  expect_res("op12",    8'h3C, 8'h00);

        issue(4'd5, 8'h93, 8'd4);    expect_res("sra 4",   8'hF9, 8'h30);
        issue(4'd4, 8'h93, 8'd4);    expect_res("srl 4",   8'h09, 8'h30);
        issue(4'd5, 8'h93, 8'd20);   expect_res("sra 20",  8'hFF, 8'hFF);
        issue(4'd4, 8'h93, 8'd16);   expect_res("srl 16",  8'h00, 8'h00);
        issue(4'd5, 8'h53, 8'd15);   expect_res("sra 15",  8'h00, 8'h00);

        issue(4'd6, 8'd5, 8'd5);     expect_res("eq t",    8'h00, 8'h00);
        check("eq t jump", 16'(bus.jump), 16'h1);
        check("eq t zero", 16'(bus.zero), 16'h1);
        issue(4'd6, 8'd5, 8'd6);
        check("eq f jump", 16'(bus.jump), 16'h0);
        issue(4'd0, 8'hF0, 8'h3C);   expect_res("and",     8'h30, 8'h00);
        check("and jump", 16'(bus.jump), 16'h0);
        check("and zero", 16'(bus.zero), 16'h0);
        tick();

        // MUL -3*5: busy 8 cycles, result on cycle 9
        issue(4'd9, 8'hFD, 8'h05);
        for (int i = 0; i < 8; i++) begin
            check("mul busy in_ready", 16'(bus.in_ready),  16'h0);
            check("mul busy valid",    16'(bus.out_valid), 16'h0);
            tick();
        end
        expect_res("mul -3*5", 8'hF1, 8'hFF);
        tick();
        issue(4'd9, 8'h80, 8'h80);
        wait_valid(20, lat);
        check("mul latency", 16'(lat), 16'd9);
        expect_res("mul -128*-128", 8'h00, 8'h40);
        check("mul zero", 16'(bus.zero), 16'h1);
        tick();

        // Backpressure with a pending op that must not be accepted
        bus.out_ready = 1'b0;
        issue(4'd3, 8'd20, 8'd30);
        bus.in_valid = 1'b1;
        bus.op       = 4'd7;
        bus.ra_in    = 8'h11;
        for (int i = 0; i < 5; i++) begin
            check("bp in_ready", 16'(bus.in_ready), 16'h0);
            expect_res("bp hold", 8'd50, 8'h00);
            tick();
        end
        bus.ra_in     = 8'h5A;
        bus.out_ready = 1'b1;
        #1;
        check("bp release in_ready", 16'(bus.in_ready), 16'h1);
        tick();
        bus.in_valid = 1'b0;
        expect_res("bp next", 8'h5A, 8'h00);
        tick();

        // Async reset mid-MUL
        issue(4'd9, 8'd7, 8'd3);
        tick(); tick();
        rst_n = 1'b0;
        #1;
        check("rst mid res",   16'(bus.res_out),   16'h0);
        check("rst mid valid", 16'(bus.out_valid), 16'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst mid idle", 16'(bus.in_ready), 16'h1);

        // Flush mid-MUL with a same-cycle op that must be ignored
        issue(4'd9, 8'd7, 8'd3);
        tick(); tick();
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.op       = 4'd7;
        bus.ra_in    = 8'h33;
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("flush idle", 16'(bus.in_ready), 16'h1);
        check("flush res",  16'(bus.res_out),  16'h0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.out_valid) seen = 1'b1;
            tick();
        end
        check("flush no valid", 16'(seen), 16'h0);
        issue(4'd9, 8'd7, 8'd3);
        wait_valid(20, lat);
        check("post flush latency", 16'(lat), 16'd9);
        expect_res("post flush mul", 8'd21, 8'h00);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
